// File: rtl/mips_pkg.sv
// Shared register-file constants for the MIPS datapath.
package mips_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;

  // Register $0 is hardwired to zero; writes to it are discarded.
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_wq_fifo.sv
// Synchronous circular-buffer FIFO holding long-latency results (dest + data)
// until the write port has a free slot. Callers never push when full or pop
// when empty.
module rf_wq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap
  // naturally at their width.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/rf_write_port.sv
// Register-file write port: merges pipeline writeback (priority, never stalled)
// with queued long-latency results, and tracks pending long-latency
// destinations in a busy scoreboard for the hazard unit.
module rf_write_port
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = REG_DW,
  parameter int unsigned AW    = REG_AW,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_wa,
  input  logic [DW-1:0]    wb_wd,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [AW-1:0]    lu_wa,
  input  logic [DW-1:0]    lu_wd,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_wa,
  output logic             we3,
  output logic [AW-1:0]    wa3,
  output logic [DW-1:0]    wd3,
  output logic [2**AW-1:0] busy,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

  logic [AW+DW-1:0] head;
  logic [AW-1:0]    head_wa;
  logic [DW-1:0]    head_wd;
  logic             wb_sel;
  logic             lu_push;
  logic             lu_pop;

  logic             we3_q, we3_d;
  logic [AW-1:0]    wa3_q, wa3_d;
  logic [DW-1:0]    wd3_q, wd3_d;
  logic [2**AW-1:0] busy_q, busy_d;

  // Ready depends only on occupancy, so a pop cannot free a slot for a push
  // in the same cycle.
  assign lu_ready = !full;
  assign lu_push  = lu_valid && lu_ready;

  // A writeback to $0 is no write at all and leaves the slot to the FIFO.
  assign wb_sel = wb_we && (wb_wa != Zero);
  assign lu_pop = !wb_sel && !empty;

  assign {head_wa, head_wd} = head;

  rf_wq_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (lu_push),
    .wdata ({lu_wa, lu_wd}),
    .pop   (lu_pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Write-port source select: writeback first, else FIFO head; address and
  // data hold when nothing is written.
  always_comb begin
    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (wb_sel) begin
      we3_d = 1'b1;
      wa3_d = wb_wa;
      wd3_d = wb_wd;
    end else if (lu_pop && (head_wa != Zero)) begin
      // A queued $0 result still consumes its slot but writes nothing.
      we3_d = 1'b1;
      wa3_d = head_wa;
      wd3_d = head_wd;
    end
  end

  // Scoreboard next state: clear on retire, then set on issue so a same-cycle
  // set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (lu_pop && (head_wa != Zero)) begin
      busy_d[head_wa] = 1'b0;
    end
    if (issue_valid && (issue_wa != Zero)) begin
      busy_d[issue_wa] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q  <= 1'b0;
      wa3_q  <= '0;
      wd3_q  <= '0;
      busy_q <= '0;
    end else begin
      we3_q  <= we3_d;
      wa3_q  <= wa3_d;
      wd3_q  <= wd3_d;
      busy_q <= busy_d;
    end
  end

  assign we3  = we3_q;
  assign wa3  = wa3_q;
  assign wd3  = wd3_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_rf_write_port.sv
// Bench for rf_write_port: a hand-computed per-cycle vector table for the
// directed corner cases, followed by randomized traffic against a queue-based
// reference model.
module tb_rf_write_port;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic        issue_valid;
  logic [4:0]  issue_wa;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] busy;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  rf_write_port #(
    .DEPTH (DEPTH),
    .DW    (32),
    .AW    (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_we       (wb_we),
    .wb_wa       (wb_wa),
    .wb_wd       (wb_wd),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_wa       (lu_wa),
    .lu_wd       (lu_wd),
    .issue_valid (issue_valid),
    .issue_wa    (issue_wa),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .busy        (busy),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  // One row = inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        lv;
    logic [4:0]  lwa;
    logic [31:0] lwd;
    logic        iv;
    logic [4:0]  iwa;
    logic        e_we3;
    logic [4:0]  e_wa3;
    logic [31:0] e_wd3;
    logic [31:0] e_busy;
    logic [2:0]  e_count;
  } vec_t;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  vec_t vecs[$];

  // Reference model state for the random phase.
  ent_t        mq[$];
  ent_t        h;
  logic [31:0] mbusy;
  logic        m_we3;
  logic [4:0]  m_wa3;
  logic [31:0] m_wd3;
  logic        m_full;

  function automatic vec_t mk(int rst, int wbe, int wba, int wbd, int lv, int lwa, int lwd,
                              int iv, int iwa, int ewe, int ewa, int ewd, int ebusy,
                              int ecnt);
    vec_t v;
    v.rst     = 1'(rst);
    v.wb_we   = 1'(wbe);
    v.wb_wa   = 5'(wba);
    v.wb_wd   = 32'(wbd);
    v.lv      = 1'(lv);
    v.lwa     = 5'(lwa);
    v.lwd     = 32'(lwd);
    v.iv      = 1'(iv);
    v.iwa     = 5'(iwa);
    v.e_we3   = 1'(ewe);
    v.e_wa3   = 5'(ewa);
    v.e_wd3   = 32'(ewd);
    v.e_busy  = 32'(ebusy);
    v.e_count = 3'(ecnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_we3, input logic [4:0] e_wa3,
                               input logic [31:0] e_wd3, input logic [31:0] e_busy,
                               input logic [2:0] e_count);
    chk({tag, ".we3"}, 64'(we3), 64'(e_we3));
    chk({tag, ".wa3"}, 64'(wa3), 64'(e_wa3));
    chk({tag, ".wd3"}, 64'(wd3), 64'(e_wd3));
    chk({tag, ".busy"}, 64'(busy), 64'(e_busy));
    chk({tag, ".count"}, 64'(count), 64'(e_count));
    chk({tag, ".full"}, 64'(full), 64'(e_count == 3'(DEPTH)));
    chk({tag, ".empty"}, 64'(empty), 64'(e_count == 3'd0));
    chk({tag, ".lu_ready"}, 64'(lu_ready), 64'(e_count != 3'(DEPTH)));
  endtask

  task automatic drive_vec(input vec_t v);
    reset       = v.rst;
    wb_we       = v.wb_we;
    wb_wa       = v.wb_wa;
    wb_wd       = v.wb_wd;
    lu_valid    = v.lv;
    lu_wa       = v.lwa;
    lu_wd       = v.lwd;
    issue_valid = v.iv;
    issue_wa    = v.iwa;
  endtask

  initial begin
    //                  rst wb wa  wd        lv lwa lwd       iv iwa  we wa wd        busy  cnt
    // reset, idle
    vecs.push_back(mk(1, 0, 0, 0,         0, 0,  0,         0, 0,  0, 0, 0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  0, 0, 0,         0, 0));
    // plain writeback, then it drops away
    vecs.push_back(mk(0, 1, 8, 'h1234,    0, 0,  0,         0, 0,  1, 8, 'h1234,    0, 0));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  0, 8, 'h1234,    0, 0));
    // issue to 9, push result two cycles later, retire clears busy[9]
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         1, 9,  0, 8, 'h1234,  1<<9, 0));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  0, 8, 'h1234,  1<<9, 0));
    vecs.push_back(mk(0, 0, 0, 0,         1, 9,  32'hDEADBEEF, 0, 0, 0, 8, 'h1234, 1<<9, 1));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  1, 9, 32'hDEADBEEF, 0, 0));
    // four pushes under sustained writeback fill the FIFO
    vecs.push_back(mk(0, 1, 1, 'h11,      1, 10, 'hA0,      0, 0,  1, 1, 'h11,      0, 1));
    vecs.push_back(mk(0, 1, 1, 'h11,      1, 11, 'hA1,      0, 0,  1, 1, 'h11,      0, 2));
    vecs.push_back(mk(0, 1, 1, 'h11,      1, 12, 'hA2,      0, 0,  1, 1, 'h11,      0, 3));
    vecs.push_back(mk(0, 1, 1, 'h11,      1, 13, 'hA3,      0, 0,  1, 1, 'h11,      0, 4));
    // fifth offered while full: refused, also on the first pop cycle
    vecs.push_back(mk(0, 1, 1, 'h11,      1, 14, 'hA4,      0, 0,  1, 1, 'h11,      0, 4));
    vecs.push_back(mk(0, 0, 0, 0,         1, 14, 'hA4,      0, 0,  1, 10, 'hA0,     0, 3));
    vecs.push_back(mk(0, 0, 0, 0,         1, 14, 'hA4,      0, 0,  1, 11, 'hA1,     0, 3));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  1, 12, 'hA2,     0, 2));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  1, 13, 'hA3,     0, 1));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  1, 14, 'hA4,     0, 0));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  0, 14, 'hA4,     0, 0));
    // set/clear collision on register 5: set wins
    vecs.push_back(mk(0, 0, 0, 0,         1, 5,  'h55,      1, 5,  0, 14, 'hA4,  1<<5, 1));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         1, 5,  1, 5, 'h55,   1<<5, 0));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  0, 5, 'h55,   1<<5, 0));
    // writeback to $0 lets the FIFO head (wa=7) through
    vecs.push_back(mk(0, 0, 0, 0,         1, 7,  'h77,      0, 0,  0, 5, 'h55,   1<<5, 1));
    vecs.push_back(mk(0, 1, 0, 'h99,      0, 0,  0,         0, 0,  1, 7, 'h77,   1<<5, 0));
    // queued $0 result: consumes a slot, pops without writing
    vecs.push_back(mk(0, 0, 0, 0,         1, 0,  'hF0,      0, 0,  0, 7, 'h77,   1<<5, 1));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  0, 7, 'h77,   1<<5, 0));
    // build count=3, then reset discards everything
    vecs.push_back(mk(0, 0, 0, 0,         1, 20, 'h20,      1, 20, 0, 7, 'h77, (1<<5)|(1<<20), 1));
    vecs.push_back(mk(0, 1, 2, 'h22,      1, 21, 'h21,      0, 0,  1, 2, 'h22, (1<<5)|(1<<20), 2));
    vecs.push_back(mk(0, 1, 3, 'h33,      1, 22, 'h22,      0, 0,  1, 3, 'h33, (1<<5)|(1<<20), 3));
    vecs.push_back(mk(1, 0, 0, 0,         0, 0,  0,         0, 0,  0, 0, 0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  0, 0, 0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 0,         0, 0,  0,         0, 0,  0, 0, 0,         0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_we3, vecs[i].e_wa3, vecs[i].e_wd3,
                    vecs[i].e_busy, vecs[i].e_count);
    end

    // Randomized traffic; writeback pressure alternates between heavy and light
    // so the FIFO both fills and drains.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset       = (cyc == 0) || ($urandom_range(0, 199) == 0);
      wb_we       = ($urandom_range(0, 99) < (((cyc / 300) % 2 == 0) ? 70 : 15));
      wb_wa       = 5'($urandom_range(0, 31));
      wb_wd       = $urandom();
      lu_valid    = ($urandom_range(0, 99) < 50);
      lu_wa       = 5'($urandom_range(0, 31));
      lu_wd       = $urandom();
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_wa    = 5'($urandom_range(0, 31));

      if (reset) begin
        mq.delete();
        mbusy = '0;
        m_we3 = 1'b0;
        m_wa3 = '0;
        m_wd3 = '0;
      end else begin
        m_full = (mq.size() == DEPTH);
        m_we3  = 1'b0;
        if (wb_we && wb_wa != 5'd0) begin
          m_we3 = 1'b1;
          m_wa3 = wb_wa;
          m_wd3 = wb_wd;
        end else if (mq.size() > 0) begin
          h = mq.pop_front();
          if (h.wa != 5'd0) begin
            m_we3        = 1'b1;
            m_wa3        = h.wa;
            m_wd3        = h.wd;
            mbusy[h.wa]  = 1'b0;
          end
        end
        if (lu_valid && !m_full) begin
          mq.push_back('{wa: lu_wa, wd: lu_wd});
        end
        if (issue_valid && issue_wa != 5'd0) begin
          mbusy[issue_wa] = 1'b1;
        end
      end

      @(posedge clk);
      #1;
      check_outputs($sformatf("rnd%0d", cyc), m_we3, m_wa3, m_wd3, mbusy, 3'(mq.size()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_port.md
Name: rf_write_port

Overview:
- Writer side of the register file's single write port (we3/wa3/wd3).
- Merges two result sources into one regfile write per cycle:
  - pipeline writeback, which always has priority and is never back-pressured;
  - the long-latency unit (DES core / multicycle ops), through a small FIFO with a valid/ready handshake.
- Keeps a per-register busy scoreboard that the hazard unit uses to stall readers of pending destinations.

Parameters:
- DEPTH, 4, number of FIFO entries for long-latency results (power of 2, at least 2).
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- wb_we  in  1  pipeline writeback enable.
- wb_wa  in  AW  pipeline writeback destination.
- wb_wd  in  DW  pipeline writeback data.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept a result.
- lu_wa  in  AW  long-latency result destination.
- lu_wd  in  DW  long-latency result data.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_wa  in  AW  destination of the issued op.
- we3  out  1  regfile write enable (registered).
- wa3  out  AW  regfile write address (registered).
- wd3  out  DW  regfile write data (registered).
- busy  out  2**AW  scoreboard; bit n=1 means register n has a pending long-latency write.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset is clk, reset: synchronous, active-high.
- Reset values: we3=0, wa3=0, wd3=0, busy=0, count=0, full=0, empty=1.
- Reset mid-operation discards all queued entries. Their busy bits clear.
- Outputs are registered with one-cycle latency: a source selected at edge k drives we3/wa3/wd3 after edge k. The regfile writes on negedge, so data is stable half a cycle before the write.
- Per-cycle arbitration, evaluated at posedge:
  1. If wb_we=1 and wb_wa!=0: output {1, wb_wa, wb_wd}. The FIFO is not popped.
  2. Else if !empty: output {1, head.wa, head.wd} and pop the head.
  3. Else: we3=0. wa3/wd3 hold their previous values.
- A wb_we=1 with wb_wa=0 counts as no write; the FIFO may pop that cycle.
- Handshake:
  - lu_ready = !full, combinational from count only. It is independent of lu_valid.
  - Push occurs when lu_valid && lu_ready.
  - When full, no push is accepted even if a pop happens the same cycle. lu_ready rises the cycle after count drops.
  - A pushed entry with lu_wa=0 is still queued and consumes a slot. When popped it drives we3=0 (write to $0 is dropped), but the slot is still consumed.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Push into an empty FIFO cannot be popped in the same cycle. Minimum lu-to-we3 latency is 2 cycles.
- FIFO:
  - Circular buffer with rd/wr pointers of width clog2(DEPTH).
  - Pointers wrap modulo DEPTH.
  - Strict FIFO order.
- Scoreboard:
  - issue_valid with issue_wa!=0 sets busy[issue_wa] at the next edge.
  - A FIFO pop with head.wa!=0 clears busy[head.wa] at the same edge that we3 is registered.
  - Same register set and cleared in the same cycle: set wins.
  - Pipeline writeback never touches busy.
  - busy[0] is always 0.
- Starvation: sustained wb_we starves the FIFO. This is acceptable, because the hazard unit stalls dependent instructions via busy and the FIFO fills, which deasserts lu_ready.
- No internal error flags. Pushing while full is impossible by construction.

Decomposition:
- Shared mips_pkg holds the constants REG_AW=5, REG_DW=32 and REG_ZERO=5'd0.
- One natural sub-module: rf_wq_fifo (parameterised DEPTH/width synchronous FIFO with count/full/empty).
- Arbitration, output registers and scoreboard stay in the top module.

Test Plan:
- Reset, then an idle cycle: we3=0, busy=0, empty=1, lu_ready=1.
- wb_we=1, wb_wa=8, wb_wd=0x1234 at edge k: we3=1, wa3=8, wd3=0x1234 after edge k; we3=0 the next cycle.
- issue_valid with issue_wa=9, then 2 cycles later a push of lu_wa=9, lu_wd=0xDEADBEEF:
  - busy[9]=1 after the issue edge;
  - we3=1, wa3=9 two cycles after the push;
  - busy[9]=0 on the same edge.
- Four back-to-back pushes (wa 10..13, wd 0xA0..0xA3) with wb_we=1 held:
  - full=1 and lu_ready=0 after the 4th push;
  - after wb_we drops, four writes emerge in order 10..13;
  - a fifth push is accepted only after the first pop.
- Set/clear collision: FIFO head wa=5 pops while issue_valid sets issue_wa=5 in the same cycle -> busy[5]=1 afterwards.
- $0 handling:
  - wb_wa=0 with FIFO head wa=7: FIFO pops, wa3=7.
  - Pushed lu_wa=0: popped with we3=0 and count decrements.
  - Reset asserted with count=3: count=0, busy=0, and no further writes.
